// File: rtl/rv32_imem_pkg.sv
// Shared types and constants for the RV32I instruction-memory loader.
package rv32_imem_pkg;

   // Loader FSM states; CSUM is only reachable when RV32_IMEM_CHECKSUM_EN is defined.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4
   } imem_load_state_t;

   // addi x0,x0,0 -- fetched while loading and for addresses past the array.
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   // Width of the little-endian word-count header.
   localparam int unsigned HDR_WIDTH = 16;

endpackage

// File: rtl/rv32_imem_array.sv
// Program-word storage: one synchronous write port, one asynchronous read port.
module rv32_imem_array
   import rv32_imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
   input  logic [31:0]                    wr_data,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
   output logic [31:0]                    rd_data
);

   logic [31:0] mem_q [DEPTH_WORDS];

   // Write the assembled word on the clock edge that accepts its last byte.
   // NOTE: the array has no reset; clearing it would force a flop-based
   // implementation and would also destroy the program a reset is meant to keep.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Zero-latency read for the fetch stage.
   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rv32_imem_loader.sv
// RV32I instruction-memory responder with a byte-serial program loader.
// Optional feature: define RV32_IMEM_CHECKSUM_EN to require an 8-bit
// zero-sum checksum byte after the data words.
module rv32_imem_loader
   import rv32_imem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] memif_addr,
   output logic [31:0] memif_data,
   input  logic        load_start,
   input  logic        load_byte_valid,
   input  logic [7:0]  load_byte,
   output logic        load_byte_ready,
   output logic        halt_pipeline,
   output logic        load_done,
   output logic        load_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   imem_load_state_t       state_q;
   logic [HDR_WIDTH-1:0]   count_q;     // word count N from the header
   logic [AW-1:0]          ptr_q;       // next word to write
   logic [1:0]             byte_cnt_q;  // byte position within the current word
   logic [23:0]            packer_q;    // bytes 0..2 of the current word
   logic                   done_q;
   logic                   error_q;
`ifdef RV32_IMEM_CHECKSUM_EN
   logic [7:0]             sum_q;       // running sum of every accepted byte
`endif

   logic                   accept;
   logic [HDR_WIDTH-1:0]   n_hdr_d;
   logic                   last_word;
   logic                   wr_en;
   logic [31:0]            wr_data_d;
   logic [31:0]            rd_word;
   logic                   addr_oob;

   assign load_byte_ready = (state_q != IDLE);
   assign halt_pipeline   = (state_q != IDLE);
   assign load_done       = done_q;
   assign load_error      = error_q;

   assign accept    = load_byte_valid && load_byte_ready;
   assign n_hdr_d   = {load_byte, count_q[7:0]};
   assign last_word = ((17'(ptr_q) + 17'd1) == {1'b0, count_q});
   assign wr_en     = accept && (state_q == DATA) && (byte_cnt_q == 2'd3);
   assign wr_data_d = {load_byte, packer_q};

   rv32_imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (ptr_q),
      .wr_data (wr_data_d),
      .rd_addr (memif_addr[AW+1:2]),
      .rd_data (rd_word)
   );

   // Fetch read mux: NOP while loading or past the end of the array.
   assign addr_oob   = ({2'b00, memif_addr} >= 32'(DEPTH_WORDS));
   assign memif_data = (halt_pipeline || addr_oob) ? NOP_WORD : rd_word;

   // Loader FSM: header parse, byte packing, completion and error flags.
   // NOTE: every register here uses <= so all of them see the pre-edge values
   // of each other; a blocking assignment would leak this cycle's update into
   // later reads within the same block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         ptr_q      <= '0;
         byte_cnt_q <= '0;
         packer_q   <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef RV32_IMEM_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_start) begin
                  state_q    <= HDR0;
                  error_q    <= 1'b0;
                  ptr_q      <= '0;
                  byte_cnt_q <= '0;
`ifdef RV32_IMEM_CHECKSUM_EN
                  sum_q      <= '0;
`endif
               end
            end
            HDR0: begin
               if (accept) begin
                  count_q[7:0] <= load_byte;
                  state_q      <= HDR1;
`ifdef RV32_IMEM_CHECKSUM_EN
                  sum_q        <= sum_q + load_byte;
`endif
               end
            end
            HDR1: begin
               if (accept) begin
                  count_q[15:8] <= load_byte;
`ifdef RV32_IMEM_CHECKSUM_EN
                  sum_q         <= sum_q + load_byte;
`endif
                  if (n_hdr_d == '0) begin
`ifdef RV32_IMEM_CHECKSUM_EN
                     state_q <= CSUM;
`else
                     state_q <= IDLE;
                     done_q  <= 1'b1;
`endif
                  end else if (32'(n_hdr_d) > 32'(DEPTH_WORDS)) begin
                     state_q <= IDLE;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
`ifdef RV32_IMEM_CHECKSUM_EN
                  sum_q <= sum_q + load_byte;
`endif
                  if (byte_cnt_q == 2'd3) begin
                     byte_cnt_q <= '0;
                     if (last_word) begin
`ifdef RV32_IMEM_CHECKSUM_EN
                        state_q <= CSUM;
`else
                        state_q <= IDLE;
                        done_q  <= 1'b1;
`endif
                     end else begin
                        ptr_q <= ptr_q + 1'b1;
                     end
                  end else begin
                     packer_q[8*byte_cnt_q +: 8] <= load_byte;
                     byte_cnt_q                  <= byte_cnt_q + 2'd1;
                  end
               end
            end
`ifdef RV32_IMEM_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  state_q <= IDLE;
                  if (8'(sum_q + load_byte) == 8'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_imem_loader.sv
// Self-checking bench for rv32_imem_loader (works with or without RV32_IMEM_CHECKSUM_EN).
module tb_rv32_imem_loader;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] memif_addr;
   logic [31:0] memif_data;
   logic        load_start;
   logic        load_byte_valid;
   logic [7:0]  load_byte;
   logic        load_byte_ready;
   logic        halt_pipeline;
   logic        load_done;
   logic        load_error;

   rv32_imem_loader #(
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .memif_addr      (memif_addr),
      .memif_data      (memif_data),
      .load_start      (load_start),
      .load_byte_valid (load_byte_valid),
      .load_byte       (load_byte),
      .load_byte_ready (load_byte_ready),
      .halt_pipeline   (halt_pipeline),
      .load_done       (load_done),
      .load_error      (load_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: expected array contents and which entries are known.
   logic [31:0] ref_mem [DEPTH];
   bit          ref_ok  [DEPTH];

   logic [31:0] words [$];
   logic [7:0]  img_q [$];
   logic [7:0]  img_sum;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] exp;
   } rd_vec_t;
   rd_vec_t rd_tab [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_b(input logic [7:0] b);
      img_q.push_back(b);
      img_sum = img_sum + b;
   endtask

   // Image = 2-byte N, N little-endian words, optional zero-sum checksum byte.
   task automatic build_image(input int n);
      logic [15:0] n16;
      n16 = 16'(n);
      img_q.delete();
      img_sum = 8'd0;
      push_b(n16[7:0]);
      push_b(n16[15:8]);
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 4; b++)
            push_b(words[i][8*b +: 8]);
`ifdef RV32_IMEM_CHECKSUM_EN
      img_q.push_back(8'(8'd0 - img_sum));
`endif
   endtask

   // Offer one byte after an optional random run of idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int gaps;
      gaps = 0;
      while (gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
         load_byte_valid = 1'b0;
         load_byte       = 8'($urandom);
         tick();
         gaps++;
      end
      check("ready_while_loading", {31'b0, load_byte_ready}, 32'd1);
      load_byte_valid = 1'b1;
      load_byte       = b;
      tick();
      load_byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("halt_after_start", {31'b0, halt_pipeline}, 32'd1);
      memif_addr = 30'd0;
      #1;
      check("nop_while_loading", memif_data, NOP);
   endtask

   task automatic send_image(input int gap_pct);
      pulse_start();
      for (int i = 0; i < img_q.size(); i++)
         send_byte(img_q[i], gap_pct);
   endtask

   task automatic expect_done(input string name);
      check({name, "_done"},  {31'b0, load_done},     32'd1);
      check({name, "_err"},   {31'b0, load_error},    32'd0);
      check({name, "_halt"},  {31'b0, halt_pipeline}, 32'd0);
      tick();
      check({name, "_done_1cyc"}, {31'b0, load_done}, 32'd0);
   endtask

   task automatic commit_words(input int n);
      for (int i = 0; i < n; i++) begin
         ref_mem[i] = words[i];
         ref_ok[i]  = 1'b1;
      end
   endtask

   task automatic verify_mem(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         if (ref_ok[i]) begin
            memif_addr = 30'(i);
            #1;
            check(name, memif_data, ref_mem[i]);
         end
      end
   endtask

   task automatic random_load(input int n, input int gap_pct);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_image(n);
      send_image(gap_pct);
      expect_done("rand_load");
      commit_words(n);
      verify_mem("rand_mem");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_tab[0] = '{addr: 30'd0,          exp: 32'h0010_0513};
      rd_tab[1] = '{addr: 30'd1,          exp: 32'h0020_0593};
      rd_tab[2] = '{addr: 30'(DEPTH),     exp: NOP};
      rd_tab[3] = '{addr: 30'(DEPTH + 7), exp: NOP};
      rd_tab[4] = '{addr: 30'h3FFF_FFFF,  exp: NOP};
      for (int i = 0; i < DEPTH; i++) ref_ok[i] = 1'b0;

      reset           = 1'b1;
      load_start      = 1'b0;
      load_byte_valid = 1'b0;
      load_byte       = 8'h00;
      memif_addr      = 30'(DEPTH);
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      check("rst_halt",  {31'b0, halt_pipeline},   32'd0);
      check("rst_ready", {31'b0, load_byte_ready}, 32'd0);
      check("rst_done",  {31'b0, load_done},       32'd0);
      check("rst_error", {31'b0, load_error},      32'd0);
      check("rst_oob_read", memif_data, NOP);

      // Directed two-word load: 02 00 | 13 05 10 00 | 93 05 20 00.
      words.delete();
      words.push_back(32'h0010_0513);
      words.push_back(32'h0020_0593);
      build_image(2);
      check("img_byte2", {24'b0, img_q[2]}, 32'h13);
      send_image(0);
      expect_done("dir_load");
      commit_words(2);
      for (int i = 0; i < 5; i++) begin
         memif_addr = rd_tab[i].addr;
         #1;
         check($sformatf("rd_tab[%0d]", i), memif_data, rd_tab[i].exp);
      end

      // Oversized header: error, no done, halt released, error sticky until next start.
      pulse_start();
      send_byte(8'((DEPTH + 1) & 8'hFF), 0);
      send_byte(8'((DEPTH + 1) >> 8), 0);
      check("ovf_error", {31'b0, load_error},    32'd1);
      check("ovf_done",  {31'b0, load_done},     32'd0);
      check("ovf_halt",  {31'b0, halt_pipeline}, 32'd0);
      repeat (3) tick();
      check("ovf_sticky", {31'b0, load_error}, 32'd1);
      pulse_start();
      check("start_clears_err", {31'b0, load_error}, 32'd0);
      // Finish this load as an empty image (N = 0).
      words.delete();
      build_image(0);
      for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], 0);
      expect_done("empty_load");
      verify_mem("after_empty");

      // 16-word random load, gap-free and again with 50% valid gaps.
      random_load(16, 0);
      random_load(16, 50);
      for (int r = 0; r < 3; r++)
         random_load(int'($urandom_range(1, 20)), (r % 2) * 50);

      // Reset after 6 data bytes of an N = 4 load.
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back($urandom);
      build_image(4);
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(img_q[i], 0);
      check("mid_halt_before_rst", {31'b0, halt_pipeline}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_halt",  {31'b0, halt_pipeline},   32'd0);
      check("mid_rst_ready", {31'b0, load_byte_ready}, 32'd0);
      check("mid_rst_done",  {31'b0, load_done},       32'd0);
      commit_words(1);
      verify_mem("mid_rst_mem");

      // A fresh load after the interrupted one.
      random_load(5, 25);

`ifdef RV32_IMEM_CHECKSUM_EN
      // Corrupted checksum byte: data lands, but error and no done.
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back($urandom);
      build_image(3);
      img_q[img_q.size()-1] = img_q[img_q.size()-1] + 8'd1;
      send_image(0);
      check("csum_bad_err",  {31'b0, load_error},    32'd1);
      check("csum_bad_done", {31'b0, load_done},     32'd0);
      check("csum_bad_halt", {31'b0, halt_pipeline}, 32'd0);
      commit_words(3);
      verify_mem("csum_bad_mem");
      random_load(3, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32_imem_loader.md
# rv32_imem_loader

Instruction-memory responder for the RV32I fetch stage. It holds program words in a word-addressed array and answers the fetch stage's `memif_addr` with `memif_data` in the same cycle. It also accepts a byte-serial program image over a valid/ready stream, writes the words into the array, and asserts `halt_pipeline` toward the core while loading. It sits beside the core top, between the fetch stage and the external program-load source (UART/debug bridge).

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `NOP_WORD`, default 32'h00000013: word returned during loading and for out-of-range addresses (`addi x0,x0,0`).
- `clk`  in  1: clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `memif_addr`  in  30 (`[31:2]`): word address from the fetch stage.
- `memif_data`  out  32: instruction word, combinational from `memif_addr`.
- `load_start`  in  1: single-cycle request to begin a load.
- `load_byte_valid`  in  1: `load_byte` is valid.
- `load_byte`  in  8: image byte.
- `load_byte_ready`  out  1: the block accepts a byte this cycle.
- `halt_pipeline`  out  1: core must hold the fetch PC and the pipeline.
- `load_done`  out  1: one-cycle pulse on successful completion.
- `load_error`  out  1: sticky error flag.

## Operation
- Image format, little-endian, loaded from word 0 upward:
  - 2 header bytes give `N` (16-bit word count).
  - Then `N` words follow, 4 bytes each, LSB first.
  - With checksum enabled, 1 checksum byte follows.
- States:
  - IDLE: `load_start` moves to HDR0.
  - HDR0: on accept, latch the low byte of `N`, go to HDR1.
  - HDR1: on accept, latch the high byte of `N`.
    - `N`=0: go to IDLE with `load_done`, or to CSUM if checksum is enabled.
    - `N`>`DEPTH_WORDS`: go to IDLE, set `load_error`, no `load_done`.
    - Otherwise go to DATA.
  - DATA: see below.
  - CSUM: compiled only with the checksum feature.
- A byte is accepted when `load_byte_valid && load_byte_ready`.
- `load_byte_ready` = 1 in HDR0, HDR1, DATA and CSUM; 0 in IDLE.
- DATA behaviour:
  - A 2-bit byte counter and a 24-bit packer hold bytes 0–2.
  - On acceptance of byte 3, write `{byte3, b2, b1, b0}` at the word pointer and increment the pointer.
  - After word `N-1` is written, go to IDLE with `load_done`, or to CSUM.
- `halt_pipeline` = (state != IDLE).
- Read port:
  - `memif_data` = `NOP_WORD` while `halt_pipeline` is high, or when `memif_addr` ≥ `DEPTH_WORDS`.
  - Otherwise `memif_data` = array[`memif_addr` low bits].
- `load_error` clears on accepted `load_start` or on `reset`.
- `load_start` outside IDLE is ignored.
- Array contents are not reset. Words not written by a load keep their prior contents.

## Timing
- Reset values:
  - State IDLE; `halt_pipeline` 0; `load_byte_ready` 0.
  - `load_done` 0; `load_error` 0; word pointer and byte counter 0.
  - `memif_data` = combinational array read (`NOP_WORD` when out of range).
- `load_start` sampled at edge k:
  - `halt_pipeline` = 1 and `load_byte_ready` = 1 from cycle k+1.
- Final byte accepted at edge m:
  - In cycle m+1: state IDLE, `halt_pipeline` 0, `load_done` 1 for exactly one cycle.
  - The written word is readable via `memif_data` from cycle m+1.
- Array write latency is 1 edge. The read port has zero latency (combinational) and is never registered.
- Stalls: cycles with `load_byte_valid` low consume nothing and change nothing. There is no timeout.
- Reset asserted mid-load:
  - Next cycle: IDLE, halt released.
  - Words already written remain; the partial packer content is discarded.
- The word pointer never exceeds `DEPTH_WORDS` − 1, so it never wraps.

## Configuration
- `RV32_IMEM_CHECKSUM_EN` defined:
  - An 8-bit running sum covers header bytes, data bytes and the checksum byte.
  - In CSUM, one byte is accepted, then the block goes to IDLE.
  - If the sum including the checksum byte is 0 mod 256: `load_done`.
  - Otherwise: `load_error` and no `load_done`.
- `RV32_IMEM_CHECKSUM_EN` undefined:
  - No CSUM state, no sum register.
  - The load completes on the last data byte.

## Structure
- Package `rv32_imem_pkg`:
  - State enum `imem_load_state_t` (IDLE, HDR0, HDR1, DATA, CSUM).
  - `NOP_WORD` default constant.
  - Header width constant (16).
- Sub-module `rv32_imem_array`: `DEPTH_WORDS`×32 array with one synchronous write port and one asynchronous read port. The loader FSM, packer and read-mux stay in `rv32_imem_loader`.

## Test plan
- Reset, then load `N`=2, bytes 02 00 | 13 05 10 00 | 93 05 20 00 → `load_done` pulse; word0=00100513, word1=00200593; `halt_pipeline` high from the cycle after `load_start` until the `load_done` cycle.
- During the above load, drive `memif_addr`=0 → `memif_data`=00000013. After load, `memif_addr`=1 → 00200593; `memif_addr`=`DEPTH_WORDS` → 00000013.
- Header `N`=`DEPTH_WORDS`+1 → `load_error`=1, no `load_done`, halt released one cycle after header byte 2. Next `load_start` clears `load_error`.
- Random `load_byte_valid` gaps (50%) on a 16-word load → identical array contents to the gap-free load.
- Reset after 6 data bytes of an `N`=4 load → halt low next cycle; word0 written, word1 keeps its old value; a new load succeeds.
- With `RV32_IMEM_CHECKSUM_EN`: correct checksum byte → `load_done`; checksum byte +1 → `load_error`, no `load_done`.
